// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: shares one physical memory port between the instruction
// side (page walker / fetch) and the data side (page walker / load-store).
//
// One memory transaction is granted at a time. The winner's request is
// registered and held on mem_* until mem_rvalid, and the response is routed
// to the owner only. A single bubble cycle in IDLE follows every access, so a
// requester that changes its address on the rvalid edge is sampled fresh.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   if_req/if_addr/if_flush   instruction-side request, address, abandon
//   if_rdata/if_rvalid        instruction-side response
//   d_req/d_addr/d_we/
//   d_wdata/d_wmask           data-side request
//   d_rdata/d_rvalid          data-side response
//   mem_req/mem_addr/mem_we/
//   mem_wdata/mem_wmask       registered request to memory
//   mem_rdata/mem_rvalid      memory response (read data or write ack)
//   timeout_err               one-cycle pulse when the response watchdog fires
//
// Build option
//   MMU_ARB_DATA_PRIORITY_EN  when defined, the data side always wins an IDLE
//                             tie; otherwise ties are resolved round-robin.
module mmu_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                if_flush,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                timeout_err
);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntD, StDrain} state_e;

  state_e           state_q;
  logic             last_if_q;  // 1: last completed owner was the IF side
  logic [CNT_W-1:0] cnt_q;

  logic             if_cand;
  logic             grant_if;
  logic             grant_d;
  logic             expired;
  logic [CNT_W-1:0] cnt_inc;

  // Response data is broadcast; only the owner's rvalid qualifies it.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // A flush in the same cycle as the response still discards it.
  assign if_rvalid = (state_q == StGntIf) && mem_rvalid && !if_flush;
  assign d_rvalid  = (state_q == StGntD) && mem_rvalid;

  // A flushing IF side is not a candidate for a new grant this cycle.
  assign if_cand = if_req && !if_flush;

`ifdef MMU_ARB_DATA_PRIORITY_EN
  assign grant_if = if_cand && !d_req;
`else
  assign grant_if = if_cand && (!d_req || !last_if_q);
`endif
  assign grant_d  = d_req && !grant_if;

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_if_q   <= 1'b0;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Stray responses while idle are ignored.
          if (grant_if) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_req   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StGntIf;
          end else if (grant_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            mem_wmask <= d_wmask;
            mem_req   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StGntD;
          end
        end
        StGntIf: begin
          if (mem_rvalid) begin
            mem_req   <= 1'b0;
            last_if_q <= 1'b1;
            state_q   <= StIdle;
          end else if (expired) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else if (if_flush) begin
            // Access stays outstanding at memory; wait it out without routing.
            cnt_q   <= '0;
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StGntD: begin
          if (mem_rvalid) begin
            mem_req   <= 1'b0;
            last_if_q <= 1'b0;
            state_q   <= StIdle;
          end else if (expired) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDrain: begin
          if (mem_rvalid) begin
            mem_req   <= 1'b0;
            last_if_q <= 1'b1;
            state_q   <= StIdle;
          end else if (expired) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
module tb_mmu_mem_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_flush, d_req, d_we;
  logic [AW-1:0]   if_addr, d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic [DW-1:0]   if_rdata, d_rdata;
  logic            if_rvalid, d_rvalid;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rvalid;
  logic            timeout_err;

  always #5 clk = ~clk;

  mmu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .if_flush(if_flush),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .timeout_err(timeout_err)
  );

  // Transaction-level model: who owns the port (0 none, 1 IF, 2 D, 3 flushed IF),
  // how many cycles the current wait has lasted, and the captured request.
  int          m_own;
  int          m_wait;
  bit          m_last_if;
  bit          m_tmo;
  logic [63:0] m_addr, m_wdata;
  bit          m_we;
  logic [7:0]  m_wmask;

  // Memory behaviour: answers mem_age==lat_cur cycles after a grant starts.
  int          mem_age, lat_cur, fix_lat;
  bit          stray_en, rand_rdata;
  logic [63:0] fix_rdata;

  // Stimulus for the next cycle.
  bit          s_if_req, s_if_flush, s_d_req, s_d_we;
  logic [63:0] s_if_addr, s_d_addr, s_d_wdata;
  logic [7:0]  s_d_wmask;

  // Observations from the most recent cycle.
  bit          o_req, o_if_rv, o_d_rv, o_tmo, o_we;
  logic [63:0] o_addr, o_rdata, o_wdata;
  logic [7:0]  o_wmask;

  int n_pass, n_checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_last_if = 1'b0; m_tmo = 1'b0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0; m_wmask = '0; mem_age = 0; lat_cur = 0;
  endtask

  function automatic int pick_lat();
    if (fix_lat >= 0) return fix_lat;
    return ($urandom % 10 == 0) ? 99 : int'($urandom % 4);
  endfunction

  // Entered and left at posedge+1.
  task automatic do_reset();
    rst = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wmask = '0; mem_rvalid = 0; mem_rdata = '0;
    s_if_req = 0; s_if_flush = 0; s_d_req = 0; s_d_we = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    bit was_busy, want_if, pick_if;
    if_req = s_if_req; if_addr = s_if_addr; if_flush = s_if_flush;
    d_req = s_d_req; d_addr = s_d_addr; d_we = s_d_we; d_wdata = s_d_wdata; d_wmask = s_d_wmask;
    if (m_own != 0) mem_rvalid = (mem_age == lat_cur);
    else            mem_rvalid = stray_en && ($urandom % 8 == 0);
    mem_rdata = rand_rdata ? {$urandom, $urandom} : fix_rdata;
    @(negedge clk);
    chk("mem_req", mem_req, m_own != 0);
    if (m_own != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end
    end
    chk("if_rvalid", if_rvalid, (m_own == 1) && mem_rvalid && !if_flush);
    chk("d_rvalid", d_rvalid, (m_own == 2) && mem_rvalid);
    chk("timeout_err", timeout_err, m_tmo);
    chk("if_rdata", if_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
    o_req = mem_req; o_if_rv = if_rvalid; o_d_rv = d_rvalid; o_tmo = timeout_err;
    o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_wmask = mem_wmask;
    o_rdata = if_rvalid ? if_rdata : d_rdata;
    // Advance the model with this cycle's inputs.
    was_busy = (m_own != 0);
    m_tmo = 1'b0;
    if (m_own == 0) begin
      want_if = if_req && !if_flush;
`ifdef MMU_ARB_DATA_PRIORITY_EN
      pick_if = want_if && !d_req;
`else
      pick_if = want_if && (!d_req || !m_last_if);
`endif
      if (pick_if) begin
        m_own = 1; m_addr = if_addr; m_we = 1'b0;
      end else if (d_req) begin
        m_own = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wmask = d_wmask;
      end
      m_wait = 0;
    end else if (mem_rvalid) begin
      m_last_if = (m_own != 2);
      m_own = 0;
    end else if (m_wait == TMO) begin
      m_own = 0; m_tmo = 1'b1;
    end else if (m_own == 1 && if_flush) begin
      m_own = 3; m_wait = 0;
    end else begin
      m_wait++;
    end
    if (!was_busy && m_own != 0) begin
      mem_age = 0; lat_cur = pick_lat();
    end else if (m_own != 0) begin
      mem_age++;
    end
    @(posedge clk); #1;
  endtask

  int          n_req, n_irv, n_drv, n_tmo, first_req, req_last, tmo_at, bad;
  logic [63:0] got;
  int          rv_owner[$];
  int          rv_cycle[$];
  bit          tr_req[16];
  logic [63:0] tr_addr[16];

  initial begin
    n_pass = 0; n_checks = 0;
    fix_lat = 0; stray_en = 0; rand_rdata = 0; fix_rdata = '0;
    s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0; s_d_wmask = '0;
    model_reset();
    @(posedge clk); #1;

    // IF read, memory latency 3.
    do_reset();
    fix_lat = 3; fix_rdata = 64'hDEADBEEF_00000013;
    s_if_req = 1; s_if_addr = 64'h8000_1000;
    n_req = 0; n_irv = 0; n_drv = 0; first_req = -1; got = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o_req) begin
        n_req++;
        if (first_req < 0) first_req = c;
      end
      if (o_if_rv) begin n_irv++; got = o_rdata; s_if_req = 0; end
      if (o_d_rv) n_drv++;
    end
    chk("t1_first_req_cycle", first_req, 1);
    chk("t1_req_cycles", n_req, 4);
    chk("t1_if_rvalid_count", n_irv, 1);
    chk("t1_if_rdata", got, 64'hDEADBEEF_00000013);
    chk("t1_d_rvalid_count", n_drv, 0);

    // Both sides held, latency 2: four-cycle accesses.
    do_reset();
    fix_lat = 2;
    s_if_req = 1; s_if_addr = 64'h1000; s_d_req = 1; s_d_addr = 64'h2000; s_d_we = 0;
    rv_owner.delete(); rv_cycle.delete();
    for (int c = 0; c < 17; c++) begin
      step();
      if (o_if_rv) begin rv_owner.push_back(1); rv_cycle.push_back(c); end
      if (o_d_rv) begin rv_owner.push_back(2); rv_cycle.push_back(c); end
    end
    s_if_req = 0; s_d_req = 0;
    chk("t2_responses", rv_owner.size(), 4);
    for (int k = 0; k < 4 && k < rv_owner.size(); k++) begin
`ifdef MMU_ARB_DATA_PRIORITY_EN
      chk("t2_owner", rv_owner[k], 2);
`else
      chk("t2_owner", rv_owner[k], (k % 2 == 0) ? 1 : 2);
`endif
      chk("t2_resp_cycle", rv_cycle[k], 3 + 4 * k);
    end

    // Masked write held until ack.
    do_reset();
    fix_lat = 2;
    s_d_req = 1; s_d_we = 1; s_d_addr = 64'h4000_0040;
    s_d_wdata = 64'h1122334455667788; s_d_wmask = 8'h0F;
    n_req = 0; n_drv = 0; bad = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (o_req) begin
        n_req++;
        if (!o_we || o_wmask != 8'h0F || o_wdata != 64'h1122334455667788 ||
            o_addr != 64'h4000_0040) bad++;
      end
      if (o_d_rv) begin n_drv++; s_d_req = 0; end
    end
    s_d_we = 0;
    chk("t3_req_cycles", n_req, 3);
    chk("t3_bad_hold_cycles", bad, 0);
    chk("t3_d_rvalid_count", n_drv, 1);

    // Flush one cycle before the response; pending data request follows.
    do_reset();
    fix_lat = 3;
    s_if_req = 1; s_if_addr = 64'h8000_2000; s_d_req = 1; s_d_addr = 64'h9000_0008;
    n_irv = 0; n_drv = 0;
    for (int c = 0; c < 12; c++) begin
      s_if_flush = (c == 3);
      if (c >= 3) s_if_req = 0;
      step();
      tr_req[c] = o_req; tr_addr[c] = o_addr;
      if (o_if_rv) n_irv++;
      if (o_d_rv) begin n_drv++; s_d_req = 0; end
    end
    s_if_flush = 0;
    chk("t4_if_rvalid_count", n_irv, 0);
    chk("t4_req_c4_drain", tr_req[4], 1);
    chk("t4_req_c5_bubble", tr_req[5], 0);
    chk("t4_req_c6_dgrant", tr_req[6], 1);
    chk("t4_addr_c6", tr_addr[6], 64'h9000_0008);
    chk("t4_d_rvalid_count", n_drv, 1);

    // Silent memory: watchdog fires, then a normal grant.
    do_reset();
    fix_lat = 99;
    s_d_req = 1; s_d_addr = 64'h30;
    n_req = 0; n_tmo = 0; req_last = -1; tmo_at = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) s_d_req = 0;
      if (o_req) begin n_req++; req_last = c; end
      if (o_tmo) begin n_tmo++; tmo_at = c; end
    end
    chk("t5_req_cycles", n_req, 5);
    chk("t5_timeout_pulses", n_tmo, 1);
    chk("t5_timeout_cycle", tmo_at, req_last + 1);
    fix_lat = 1; s_d_req = 1; n_drv = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_d_rv) begin n_drv++; s_d_req = 0; end
    end
    chk("t5_regrant_d_rvalid", n_drv, 1);

    // Randomized traffic with stray responses, flushes and occasional resets.
    do_reset();
    fix_lat = -1; rand_rdata = 1; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      s_if_req   = ($urandom % 2 == 0);
      s_d_req    = ($urandom % 2 == 0);
      s_if_flush = ($urandom % 6 == 0);
      s_if_addr  = {$urandom, $urandom};
      s_d_addr   = {$urandom, $urandom};
      s_d_we     = ($urandom % 2 == 0);
      s_d_wdata  = {$urandom, $urandom};
      s_d_wmask  = 8'($urandom);
      if ($urandom % 300 == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
